// File: rtl/ws_sta_seq_ctrl_if.sv
// Control/handshake bundle between the host-side feeders and the systolic-array sequencer.
// The master side drives the requests and feeder valids; the slave side is the sequencer.
interface ws_sta_seq_ctrl_if #(
  parameter int ROWS  = 16,
  parameter int CNT_W = 8
);
  logic             io_start;
  logic [CNT_W-1:0] io_cfgNumA;
  logic             io_busy;
  logic             io_done;
  logic             io_bValid;
  logic             io_bReady;
  logic [ROWS-1:0]  io_propagateB;
  logic             io_aValid;
  logic             io_aReady;
  logic             io_aGate;
  logic             io_cValid;
  logic [CNT_W-1:0] io_cIndex;

  modport master (
    output io_start, io_cfgNumA, io_bValid, io_aValid,
    input  io_busy, io_done, io_bReady, io_propagateB,
           io_aReady, io_aGate, io_cValid, io_cIndex
  );

  modport slave (
    input  io_start, io_cfgNumA, io_bValid, io_aValid,
    output io_busy, io_done, io_bReady, io_propagateB,
           io_aReady, io_aGate, io_cValid, io_cIndex
  );
endinterface

// File: rtl/ws_sta_seq_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight preload, A streaming,
// drain, with a valid shift pipe that tags each result vector with its ordinal.
module ws_sta_seq_ctrl #(
  parameter int ROWS      = 16,
  parameter int DRAIN_LAT = 31,
  parameter int CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  ws_sta_seq_ctrl_if.slave  bus
);
  localparam int BW = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_B   = 3'd1,
    STREAM_A = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t               state_r;
  state_t               nextState_s;
  logic [CNT_W-1:0]     numA_r;
  logic [BW-1:0]        bCnt_r;
  logic [CNT_W-1:0]     aCnt_r;
  logic [CNT_W-1:0]     outCnt_r;
  logic [DRAIN_LAT-1:0] pipe_r;
  logic [DRAIN_LAT-1:0] pipeNext_s;
  logic                 startAccept_s;
  logic                 bAccept_s;
  logic                 aAccept_s;
  logic                 shiftEn_s;
  logic                 pipeOut_s;

  assign pipeOut_s  = pipe_r[DRAIN_LAT-1];
  assign pipeNext_s = (pipe_r << 1) | DRAIN_LAT'(aAccept_s);

  // Next-state decode and output strobes; all outputs forced low while reset is asserted.
  always_comb begin
    nextState_s       = state_r;
    startAccept_s     = 1'b0;
    bAccept_s         = 1'b0;
    aAccept_s         = 1'b0;
    shiftEn_s         = 1'b0;
    bus.io_busy       = 1'b0;
    bus.io_done       = 1'b0;
    bus.io_bReady     = 1'b0;
    bus.io_propagateB = '0;
    bus.io_aReady     = 1'b0;
    bus.io_aGate      = 1'b0;
    bus.io_cValid     = 1'b0;
    bus.io_cIndex     = '0;
    if (reset) begin
      nextState_s = IDLE;
    end else begin
      bus.io_cValid = pipeOut_s;
      bus.io_cIndex = outCnt_r;
      case (state_r)
        IDLE: begin
          if (bus.io_start && (bus.io_cfgNumA != '0)) begin
            startAccept_s = 1'b1;
            nextState_s   = LOAD_B;
          end else begin
            nextState_s = IDLE;
          end
        end
        LOAD_B: begin
          bus.io_busy       = 1'b1;
          bus.io_bReady     = 1'b1;
          bus.io_propagateB = {ROWS{bus.io_bValid}};
          bAccept_s         = bus.io_bValid;
          if (bus.io_bValid && (bCnt_r == BW'(ROWS - 1))) begin
            nextState_s = STREAM_A;
          end else begin
            nextState_s = LOAD_B;
          end
        end
        STREAM_A: begin
          bus.io_busy   = 1'b1;
          bus.io_aReady = 1'b1;
          bus.io_aGate  = bus.io_aValid;
          aAccept_s     = bus.io_aValid;
          shiftEn_s     = 1'b1;
          if (bus.io_aValid && (aCnt_r == (numA_r - CNT_W'(1)))) begin
            nextState_s = DRAIN;
          end else begin
            nextState_s = STREAM_A;
          end
        end
        DRAIN: begin
          bus.io_busy = 1'b1;
          shiftEn_s   = 1'b1;
          if (pipeOut_s && (outCnt_r == (numA_r - CNT_W'(1)))) begin
            nextState_s = DONE;
          end else begin
            nextState_s = DRAIN;
          end
        end
        DONE: begin
          bus.io_busy = 1'b1;
          bus.io_done = 1'b1;
          nextState_s = IDLE;
        end
        default: begin
          nextState_s = IDLE;
        end
      endcase
    end
  end

  // State, job length, beat counters and latency pipe; cleared on job start and after DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      numA_r   <= '0;
      bCnt_r   <= '0;
      aCnt_r   <= '0;
      outCnt_r <= '0;
      pipe_r   <= '0;
    end else begin
      state_r <= nextState_s;
      if (startAccept_s) begin
        numA_r   <= bus.io_cfgNumA;
        bCnt_r   <= '0;
        aCnt_r   <= '0;
        outCnt_r <= '0;
        pipe_r   <= '0;
      end else if (state_r == DONE) begin
        numA_r   <= '0;
        bCnt_r   <= '0;
        aCnt_r   <= '0;
        outCnt_r <= '0;
        pipe_r   <= '0;
      end else begin
        if (bAccept_s) begin
          bCnt_r <= bCnt_r + BW'(1);
        end
        if (aAccept_s) begin
          aCnt_r <= aCnt_r + CNT_W'(1);
        end
        if (shiftEn_s) begin
          pipe_r <= pipeNext_s;
        end
        if (pipeOut_s) begin
          outCnt_r <= outCnt_r + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ws_sta_seq_ctrl.sv
// Scoreboard bench for ws_sta_seq_ctrl: directed jobs push expected cValid/done events,
// a negedge monitor pops and compares them; control strobes are checked cycle by cycle.
module tb_ws_sta_seq_ctrl;
  localparam int ROWS      = 16;
  localparam int DRAIN_LAT = 31;
  localparam int CNT_W     = 8;

  typedef struct {
    bit isDone;
    int cyc;
    int idx;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  expQ[$];
  ev_t  pend[$];

  ws_sta_seq_ctrl_if #(.ROWS(ROWS), .CNT_W(CNT_W)) bus ();

  ws_sta_seq_ctrl #(.ROWS(ROWS), .DRAIN_LAT(DRAIN_LAT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Result/done monitor: every presented event must match the head of the scoreboard.
  always @(negedge clock) begin
    ev_t e;
    if (!reset && (bus.io_cValid === 1'b1 || bus.io_done === 1'b1)) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got cValid=%b done=%b idx=%0d required none",
                 cyc, bus.io_cValid, bus.io_done, bus.io_cIndex);
      end else begin
        e = expQ.pop_front();
        if ((e.isDone !== bus.io_done) || (e.isDone === bus.io_cValid) || (e.cyc != cyc) ||
            (!e.isDone && (e.idx != int'(bus.io_cIndex))) || (e.isDone && bus.io_busy !== 1'b1)) begin
          failures++;
          $display("FAIL event cyc=%0d got cValid=%b done=%b idx=%0d busy=%b required %s at cyc=%0d idx=%0d",
                   cyc, bus.io_cValid, bus.io_done, bus.io_cIndex, bus.io_busy,
                   e.isDone ? "done" : "cValid", e.cyc, e.idx);
        end
      end
    end
  end

  task automatic expC(input int rel, input int idx);
    ev_t e;
    e.isDone = 1'b0; e.cyc = rel; e.idx = idx;
    pend.push_back(e);
  endtask

  task automatic expDone(input int rel);
    ev_t e;
    e.isDone = 1'b1; e.cyc = rel; e.idx = 0;
    pend.push_back(e);
  endtask

  // One job: start at relative cycle 0, drive feeder valids, check control strobes each cycle.
  task automatic runJob(input int numA, input int lastK, input int loadEnd, input int streamEnd,
                        input int doneCyc, input int stallLo, input int stallHi, input int bubble,
                        input int resetCyc, input int secondStart);
    logic        bv, av, act, inLoad, inStream, busyE;
    logic [19:0] expV, gotV;
    ev_t         e;
    for (int k = 0; k <= lastK; k++) begin
      bv = !(k >= stallLo && k <= stallHi);
      av = (k != bubble);
      @(posedge clock);
      #1;
      bus.io_start   = (k == 0) || (k == secondStart);
      bus.io_cfgNumA = CNT_W'(numA);
      bus.io_bValid  = bv;
      bus.io_aValid  = av;
      reset          = (k == resetCyc);
      if (k == 0) begin
        base = cyc;
        while (pend.size() > 0) begin
          e = pend.pop_front();
          e.cyc = e.cyc + base;
          expQ.push_back(e);
        end
      end
      @(negedge clock);
      act      = (resetCyc < 0) || (k < resetCyc);
      inLoad   = act && (k >= 1) && (k <= loadEnd);
      inStream = act && (k > loadEnd) && (k <= streamEnd);
      busyE    = act && (k >= 1) && (k <= doneCyc);
      expV = {busyE, inLoad, (inLoad && bv) ? 16'hFFFF : 16'h0000, inStream, inStream && av};
      gotV = {bus.io_busy, bus.io_bReady, bus.io_propagateB, bus.io_aReady, bus.io_aGate};
      checks++;
      if (gotV !== expV) begin
        failures++;
        $display("FAIL ctl k=%0d got busy/bRdy/propB/aRdy/aGate=%h required %h", k, gotV, expV);
      end
    end
    @(posedge clock);
    #1;
    bus.io_start  = 1'b0;
    bus.io_bValid = 1'b0;
    bus.io_aValid = 1'b0;
    reset         = 1'b0;
  endtask

  initial begin
    logic [24:0] allOut;
    bus.io_start   = 1'b1;
    bus.io_cfgNumA = 8'd4;
    bus.io_bValid  = 1'b1;
    bus.io_aValid  = 1'b1;
    reset          = 1'b1;

    // Reset held two cycles with start asserted.
    repeat (2) @(posedge clock);
    @(negedge clock);
    allOut = {bus.io_busy, bus.io_done, bus.io_bReady, bus.io_propagateB,
              bus.io_aReady, bus.io_aGate, bus.io_cValid, bus.io_cIndex[3:0]};
    checks++;
    if (allOut !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h required 0", allOut);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.io_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus.io_busy !== 1'b0 || bus.io_bReady !== 1'b0 || bus.io_cIndex !== 8'd0) begin
        failures++;
        $display("FAIL idle_after_reset i=%0d got busy=%b bReady=%b idx=%0d required 0/0/0",
                 i, bus.io_busy, bus.io_bReady, bus.io_cIndex);
      end
    end

    // Nominal job, numA=4.
    expC(48, 0); expC(49, 1); expC(50, 2); expC(51, 3); expDone(52);
    runJob(4, 55, 16, 20, 52, -1, -1, -1, -1, -1);

    // Weight stall in cycles 5-7 shifts everything by 3.
    expC(51, 0); expC(52, 1); expC(53, 2); expC(54, 3); expDone(55);
    runJob(4, 58, 19, 23, 55, 5, 7, -1, -1, -1);

    // A bubble in the second STREAM_A cycle, numA=3.
    expC(48, 0); expC(50, 1); expC(51, 2); expDone(52);
    runJob(3, 55, 16, 20, 52, -1, -1, 18, -1, -1);

    // Start with numA=0 is ignored.
    runJob(0, 6, 0, 0, 0, -1, -1, -1, -1, -1);

    // Second start during LOAD_B is ignored, numA=2.
    expC(48, 0); expC(49, 1); expDone(50);
    runJob(2, 54, 16, 18, 50, -1, -1, -1, -1, 5);

    // Reset in cycle 18 aborts the job with no further events for 60 cycles.
    runJob(4, 78, 16, 20, 52, -1, -1, -1, 18, -1);

    // Fresh nominal job after the aborted one.
    expC(48, 0); expC(49, 1); expC(50, 2); expC(51, 3); expDone(52);
    runJob(4, 55, 16, 20, 52, -1, -1, -1, -1, -1);

    repeat (5) @(posedge clock);
    @(negedge clock);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty got %0d pending events required 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
